// File: rtl/texture_block_fetch_pkg.sv
// Shared render definitions for the R8 texture block fetch path.
// Holds the FSM state encoding and the block geometry constants.
package texture_block_fetch_pkg;

  localparam int TEX_BLK_BEATS = 8;
  localparam int TEX_BLK_BITS  = 128;
  localparam int TEX_BEAT_W    = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RECV  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/texture_block_fetch.sv
// Fetches one 4x4 R8 texture block as an 8-beat 16-bit SDRAM burst and
// assembles it into a row-major 128-bit block word with a valid/ready output.
module texture_block_fetch
  import texture_block_fetch_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int BEATS  = TEX_BLK_BEATS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic                    flush,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic                    mem_rvalid,
  input  logic [TEX_BEAT_W-1:0]   mem_rdata,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic [TEX_BLK_BITS-1:0] blk_data,
  output logic [ADDR_W-1:0]       blk_addr
);

  localparam int CNT_W = $clog2(BEATS);

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   beat_cnt_reg;
  logic [ADDR_W-1:0]  mem_addr_reg;
  logic [ADDR_W-1:0]  blk_addr_reg;
  logic               last_beat;
  logic               accept;
  logic               beat_we;

  assign last_beat = (beat_cnt_reg == CNT_W'(BEATS - 1));
  assign accept    = (state_reg == IDLE) && req_valid && !flush;
  // A beat arriving in the flush cycle is counted but never stored.
  assign beat_we   = (state_reg == RECV) && mem_rvalid && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid && !flush) state_next = REQ;
      end
      REQ: begin
        if (mem_ack && flush)  state_next = DRAIN;
        else if (mem_ack)      state_next = RECV;
        else if (flush)        state_next = IDLE;
      end
      RECV: begin
        // Flushing on the final beat leaves nothing to drain.
        if (flush)                         state_next = (mem_rvalid && last_beat) ? IDLE : DRAIN;
        else if (mem_rvalid && last_beat)  state_next = HOLD;
      end
      DRAIN: begin
        if (mem_rvalid && last_beat) state_next = IDLE;
      end
      HOLD: begin
        if (blk_ready || flush) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_reg == IDLE);
    mem_req   = (state_reg == REQ);
    blk_valid = (state_reg == HOLD);
    mem_addr  = mem_addr_reg;
    blk_addr  = blk_addr_reg;
  end

  // Count wraps to zero after the last beat, ready for the next burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_reg <= '0;
    end else if ((state_reg == REQ) && mem_ack) begin
      beat_cnt_reg <= '0;
    end else if (((state_reg == RECV) || (state_reg == DRAIN)) && mem_rvalid) begin
      beat_cnt_reg <= beat_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr_reg <= '0;
      blk_addr_reg <= '0;
    end else begin
      if (accept) mem_addr_reg <= req_addr;
      if (beat_we && last_beat) blk_addr_reg <= mem_addr_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_lane
      logic [TEX_BEAT_W-1:0] lane_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_reg <= '0;
        end else if (beat_we && (beat_cnt_reg == CNT_W'(gi))) begin
          lane_reg <= mem_rdata;
        end
      end

      assign blk_data[gi*TEX_BEAT_W +: TEX_BEAT_W] = lane_reg;
    end
  endgenerate

endmodule

// File: doc/texture_block_fetch.md
# texture_block_fetch

Fetches one 4x4 R8 texture block (128 bits, 16 texels × 8 bits) from SDRAM as an 8-beat, 16-bit burst and assembles it into the row-major block word consumed by the R8 decoder / texture cache fill path. It sits between the texture cache miss logic (upstream request) and the SDRAM arbiter port (memory side). It presents the assembled block downstream with a valid/ready handshake. It supports a flush that cancels or drains an in-flight fetch without emitting data.

## Interface
- ADDR_W, 24, SDRAM 16-bit word address width
- BEATS, 8, 16-bit words per block (fixed; 128/16)
- clk  in  1  core clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  block fetch request
- req_ready  out  1  high only in IDLE
- req_addr  in  ADDR_W  block base word address; latched on handshake
- flush  in  1  synchronous cancel of current/pending fetch
- mem_req  out  1  burst read request to arbiter
- mem_addr  out  ADDR_W  burst base address (latched req_addr)
- mem_ack  in  1  arbiter accepted burst (single-cycle pulse)
- mem_rvalid  in  1  read beat valid
- mem_rdata  in  16  read beat data
- blk_valid  out  1  assembled block available
- blk_ready  in  1  downstream accepts block
- blk_data  out  128  texel t at bits [8t+7:8t]
- blk_addr  out  ADDR_W  base address tag of blk_data

## Operation
- States: IDLE, REQ, RECV, DRAIN, HOLD.
- IDLE: req_ready=1. On req_valid && !flush → latch req_addr, go to REQ. If req_valid and flush are both high, the request is not accepted.
- REQ: mem_req=1, mem_addr stable.
  - mem_ack → clear beat count, go to RECV.
  - flush without ack → IDLE, with mem_req low the next cycle.
  - flush and mem_ack in the same cycle → DRAIN.
- RECV: each mem_rvalid writes mem_rdata to blk_data[16k+15:16k], where k = beat count. Low byte is texel 2k; high byte is texel 2k+1.
  - The 3-bit beat count increments per beat. On the 8th beat (k=7) → HOLD.
  - flush → DRAIN, keeping the current beat count. A beat arriving in the flush cycle is counted, not stored.
- DRAIN: counts remaining beats without writing blk_data. After the 8th beat total → IDLE. Never asserts blk_valid.
- HOLD: blk_valid=1; blk_data and blk_addr are stable.
  - blk_ready → IDLE.
  - flush → IDLE with blk_valid dropped. If blk_ready and flush are high in the same cycle, the transfer counts as completed.
- mem_rvalid in IDLE, REQ or HOLD is ignored. No state writes blk_data except RECV.
- Reset (asynchronous, any state, including mid-burst): state=IDLE, req_ready=1 after release, mem_req=0, blk_valid=0, beat count=0, blk_data=0, blk_addr=0, mem_addr=0. The arbiter is responsible for discarding the orphaned burst.

## Timing
- All outputs are registered or decoded from the state register; no combinational path from blk_ready or mem_rvalid to outputs.
- Request accepted at cycle 0 → mem_req high at cycle 1.
- mem_ack at cycle a → earliest counted beat at cycle a+1.
- 8th beat at cycle b → blk_valid high at cycle b+1. Minimum request-to-blk_valid latency is 10 cycles with ack at cycle 1 and gapless beats.
- Beats may have gaps of any length; the count does not advance without mem_rvalid.
- Throughput: one block per burst. HOLD→IDLE costs 1 cycle, so the next req_valid is accepted the cycle after blk_ready.
- mem_addr changes only on request acceptance.

## Structure
- Shared render package holds:
  - state enum: IDLE, REQ, RECV, DRAIN, HOLD
  - constant TEX_BLK_BEATS=8
  - constant TEX_BLK_BITS=128
- No sub-modules: one FSM plus beat counter and a 128-bit assembly register with per-beat write enables.

## Test plan
- Request addr 0x001240, ack at cycle 1, beats 0x0100, 0x0302 … 0x0F0E gapless → blk_valid at cycle 10; blk_data[8t+7:8t]=t for t=0..15; blk_addr=0x001240.
- Random 0–5 cycle gaps between beats, plus stray mem_rvalid in IDLE/HOLD → blk_data identical to the gapless case; stray beats are not stored.
- blk_ready held low for 20 cycles → blk_valid and blk_data stable; req_ready=0 throughout; the next request is accepted the cycle after blk_ready.
- flush after beat 3 → DRAIN absorbs beats 4–8, no blk_valid; blk_data unchanged from the prior block; the next request completes normally.
- flush in REQ before ack → mem_req low the next cycle, IDLE, no beats counted; flush coincident with mem_ack → all 8 beats drained.
- rst asserted after beat 5 → all outputs reach reset values immediately (asynchronously); after release, a new request completes with correct data.
